apb_slave_regbank: RTL and testbench
====================================

Name: apb_slave_regbank

Overview:
- APB3 completer (slave) register bank sitting on one `psel` bit of the bridge's APB master port; the responder end of the bridge's APB interface.
- Decodes `NUM_REGS` word registers with a parameterised number of wait states.
- Returns PSLVERR on unmapped, misaligned or read-only-write accesses, and keeps a saturating error counter.
- Used as the bench target and as the first real peripheral behind the bridge.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width; register width.
- BASE_ADDR, 32'h0000_0000, byte address of register 0.
- NUM_REGS, 16, number of word registers; decoded window is NUM_REGS*4 bytes.
- WAIT_STATES, 0, extra access-phase cycles before PREADY (0..15).
- ID_VALUE, 32'hA2B0_0001, read-only contents of register 0.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- psel_i  input  1  completer select.
- penable_i  input  1  APB access phase.
- pwrite_i  input  1  1 = write, 0 = read.
- paddr_i  input  ADDR_WIDTH  byte address.
- pwdata_i  input  DATA_WIDTH  write data.
- prdata_o  output  DATA_WIDTH  read data; valid only while pready_o=1, else 0.
- pready_o  output  1  transfer complete.
- pslverr_o  output  1  error response; valid only while pready_o=1, else 0.
- err_cnt_o  output  8  saturating count of PSLVERR responses.
- prot_err_o  output  1  sticky protocol violation flag (see Optional Feature).

Behaviour:
- Reset (rst=1, async): state=IDLE, all RW registers=0, wait counter=0, err_cnt_o=0, prot_err_o=0, pready_o=0, pslverr_o=0, prdata_o=0. Reset asserted mid-access aborts the transfer with no register update.
- FSM states IDLE, ACCESS.
  - IDLE -> ACCESS when psel_i=1 and penable_i=0 (setup phase). On that edge: capture paddr_i, pwrite_i, pwdata_i; load wait counter with WAIT_STATES.
  - ACCESS: counter decrements each cycle while nonzero.
  - pready_o = (state==ACCESS) && (counter==0) && psel_i && penable_i, combinational from registered state/counter. Access phase therefore lasts WAIT_STATES+1 cycles.
  - ACCESS -> IDLE on the cycle pready_o=1 (transfer retires).
  - ACCESS -> IDLE with no effect if psel_i drops before pready_o.
  - Back-to-back: a new setup in the cycle after retirement is accepted from IDLE with no dead cycle.
- Decode uses the captured address: offset = addr - BASE_ADDR, computed in ADDR_WIDTH bits.
  - Hit when offset < NUM_REGS*4 and addr[1:0]==0.
  - Index = offset[ $clog2(NUM_REGS)+1 : 2 ].
- Error (pslverr_o=1 at pready_o) when any of:
  - the decode misses;
  - the address is misaligned;
  - the access is a write to register 0.
- Errored writes change no register. Errored reads return prdata_o=0.
- Write commit: register[index] <= captured wdata on the clock edge where pready_o=1 and no error.
- Read: prdata_o = register[index] (register 0 = ID_VALUE), driven while pready_o=1.
- err_cnt_o increments on each retired errored transfer and saturates at 8'hFF (no wrap).
- Signals sampled in ACCESS are the captured copies; changes to paddr_i, pwrite_i or pwdata_i during ACCESS are ignored by the datapath.

Optional Feature:
- Macro `APB_SLAVE_PROT_CHECK_EN`.
- Defined: prot_err_o is set (sticky until rst) on any of:
  - penable_i=1 while psel_i=1 in IDLE (access phase without setup);
  - paddr_i, pwrite_i or pwdata_i differing from the captured value during ACCESS;
  - psel_i dropped during ACCESS before pready_o.
- Not defined: prot_err_o is tied to 0 and the checker logic is absent. Datapath behaviour is identical either way.

Decomposition:
- Package `apb_slave_pkg`:
  - state enum {IDLE, ACCESS};
  - constants APB_RESP_OK=1'b0, APB_RESP_ERR=1'b1, REG_ID_IDX=0;
  - function computing the word index from an offset.
- One sub-module `apb_prot_checker`, instantiated only under `APB_SLAVE_PROT_CHECK_EN`.
  - Inputs: APB signals, FSM state, captured address/control/data.
  - Output: sticky violation flag.

Test Plan:
- WAIT_STATES=0: write 0x1234_5678 to 0x08, then read 0x08 -> pready_o in first access cycle both times; prdata_o=0x1234_5678; pslverr_o=0.
- WAIT_STATES=3: read 0x00 -> pready_o low for 3 access cycles and high on the 4th; prdata_o=0xA2B0_0001.
- Errors:
  - write to 0x00, 0x40 and 0x06 -> pslverr_o=1 each time;
  - no register changes;
  - err_cnt_o=3.
- 300 consecutive errored reads -> err_cnt_o saturates at 0xFF; then a valid read still returns correct data with pslverr_o=0.
- Back-to-back:
  - write 0x0C then read 0x0C with a setup immediately after pready -> read returns the new data with no idle cycle;
  - assert rst mid-access -> outputs return to 0 and the register is unchanged.
- With `APB_SLAVE_PROT_CHECK_EN`:
  - change paddr_i during a wait state -> prot_err_o=1 and stays set;
  - without the macro -> prot_err_o=0 throughout.

Source files
------------

// File: rtl/apb_slave_regbank_pkg.sv
// Shared types and constants for the APB3 completer register bank.
package apb_slave_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic        APB_RESP_OK  = 1'b0;
  localparam logic        APB_RESP_ERR = 1'b1;
  localparam int unsigned REG_ID_IDX   = 0;

  // Word index of a byte offset; the caller truncates to its index width.
  function automatic logic [31:0] word_index(input logic [31:0] offset);
    return offset >> 2;
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB3 bus bundle between a requester and the register bank completer.
interface apb_slave_regbank_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pready_o;
  logic                  pslverr_o;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

endinterface

// File: rtl/apb_slave_regbank_prot_checker.sv
// Sticky APB protocol violation monitor for the register bank.
// Only compiled when APB_SLAVE_PROT_CHECK_EN is defined.
`ifdef APB_SLAVE_PROT_CHECK_EN
module apb_prot_checker
  import apb_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  input  logic [0:0]            i_state,
  input  logic [ADDR_WIDTH-1:0] i_cap_addr,
  input  logic                  i_cap_write,
  input  logic [DATA_WIDTH-1:0] i_cap_wdata,
  output logic                  o_prot_err
);

  logic w_in_access;
  logic w_violation;
  logic r_prot_err;

  assign w_in_access = (i_state == 1'(ACCESS));

  // Access without setup, unstable payload, or select dropped before completion.
  assign w_violation =
      (!w_in_access && i_psel && i_penable) ||
      (w_in_access && i_psel && ((i_paddr != i_cap_addr) ||
                                 (i_pwrite != i_cap_write) ||
                                 (i_pwdata != i_cap_wdata))) ||
      (w_in_access && !i_psel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prot_err <= 1'b0;
    end else if (w_violation) begin
      r_prot_err <= 1'b1;
    end
  end

  assign o_prot_err = r_prot_err;

endmodule
`endif

// File: rtl/apb_slave_regbank.sv
// APB3 completer with NUM_REGS word registers, wait states and error counting.
// Define APB_SLAVE_PROT_CHECK_EN to build the sticky protocol checker.
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA2B0_0001)
) (
  input  logic                clk,
  input  logic                rst,
  apb_slave_regbank_if.slave  bus,
  output logic [7:0]          err_cnt_o,
  output logic                prot_err_o
);

  localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned WIN_BYTES = NUM_REGS * 4;
  localparam int unsigned CNT_W     = 4;
  localparam logic [0:0]  S_IDLE    = 1'(IDLE);
  localparam logic [0:0]  S_ACCESS  = 1'(ACCESS);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [7:0]            r_err_cnt;

  logic                  w_setup;
  logic                  w_pready;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_err;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Decode always works on the captured address so mid-access changes are ignored.
  assign w_offset = r_addr - BASE_ADDR;
  assign w_hit    = (w_offset < ADDR_WIDTH'(WIN_BYTES)) && (r_addr[1:0] == 2'b00);
  assign w_idx    = IDX_W'(word_index(32'(w_offset)));
  assign w_err    = !w_hit || (r_write && (w_idx == IDX_W'(REG_ID_IDX)));
  assign w_rdata  = (w_idx == IDX_W'(REG_ID_IDX)) ? ID_VALUE : r_regs[w_idx];

  assign w_setup  = (r_state == S_IDLE) && bus.psel_i && !bus.penable_i;
  assign w_pready = (r_state == S_ACCESS) && (r_wait_cnt == '0) &&
                    bus.psel_i && bus.penable_i;
  assign w_commit = w_pready && !w_err && r_write;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_setup) w_state_nxt = S_ACCESS;
      S_ACCESS: if (!bus.psel_i || w_pready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_setup) begin
        r_addr     <= bus.paddr_i;
        r_write    <= bus.pwrite_i;
        r_wdata    <= bus.pwdata_i;
        r_wait_cnt <= CNT_W'(WAIT_STATES);
      end else if ((r_state == S_ACCESS) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[w_idx] <= r_wdata;
    end
  end

  // Saturating count of retired error responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_pready && w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.pready_o  = w_pready;
  assign bus.pslverr_o = (w_pready && w_err) ? APB_RESP_ERR : APB_RESP_OK;
  assign bus.prdata_o  = (w_pready && !w_err && !r_write) ? w_rdata : '0;
  assign err_cnt_o     = r_err_cnt;

`ifdef APB_SLAVE_PROT_CHECK_EN
  apb_prot_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_prot_checker (
    .clk         (clk),
    .rst         (rst),
    .i_psel      (bus.psel_i),
    .i_penable   (bus.penable_i),
    .i_pwrite    (bus.pwrite_i),
    .i_paddr     (bus.paddr_i),
    .i_pwdata    (bus.pwdata_i),
    .i_state     (r_state),
    .i_cap_addr  (r_addr),
    .i_cap_write (r_write),
    .i_cap_wdata (r_wdata),
    .o_prot_err  (prot_err_o)
  );
`else
  assign prot_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed scoreboard bench for apb_slave_regbank: instance A has no wait
// states, instance B has three.
module tb_apb_slave_regbank;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] waits;
  } exp_t;

  localparam logic [31:0] ID = 32'hA2B0_0001;
`ifdef APB_SLAVE_PROT_CHECK_EN
  localparam logic EXP_PROT_B = 1'b1;
`else
  localparam logic EXP_PROT_B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] err_cnt_a, err_cnt_b;
  logic       prot_a, prot_b;

  always #5 clk = ~clk;

  apb_slave_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) busa ();
  apb_slave_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) busb ();

  apb_slave_regbank #(.WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(rst_a), .bus(busa), .err_cnt_o(err_cnt_a), .prot_err_o(prot_a)
  );
  apb_slave_regbank #(.WAIT_STATES(3)) dut_b (
    .clk(clk), .rst(rst_b), .bus(busb), .err_cnt_o(err_cnt_b), .prot_err_o(prot_b)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  logic [31:0] shadow [2][16];
  int unsigned mcnt [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic sel, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (b) begin
      busb.psel_i = sel; busb.penable_i = en; busb.pwrite_i = wr;
      busb.paddr_i = a;  busb.pwdata_i = d;
    end else begin
      busa.psel_i = sel; busa.penable_i = en; busa.pwrite_i = wr;
      busa.paddr_i = a;  busa.pwdata_i = d;
    end
  endtask

  task automatic sample(input bit b, output logic rdy, output logic err,
                        output logic [31:0] rd, output logic [7:0] cnt, output logic prot);
    if (b) begin
      rdy = busb.pready_o; err = busb.pslverr_o; rd = busb.prdata_o;
      cnt = err_cnt_b; prot = prot_b;
    end else begin
      rdy = busa.pready_o; err = busa.pslverr_o; rd = busa.prdata_o;
      cnt = err_cnt_a; prot = prot_a;
    end
  endtask

  function automatic bit model_err(input bit wr, input logic [31:0] a);
    return (a >= 32'd64) || (a[1:0] != 2'b00) || (wr && (a[5:2] == 4'd0));
  endfunction

  task automatic idle(input bit b);
    drive(b, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic reset_model(input bit b);
    for (int i = 0; i < 16; i++) shadow[b][i] = 32'h0;
    mcnt[b] = 0;
  endtask

  // Entered and left at #1 after a rising edge; psel stays high on exit so a
  // following call forms a back-to-back transfer.
  task automatic xfer(input bit b, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input bit glitch);
    exp_t        e;
    logic        rdy, err, prot;
    logic [31:0] rd;
    logic [7:0]  cnt;
    int          waits;
    bit          got;
    logic [3:0]  idx;

    idx     = a[5:2];
    e.err   = model_err(wr, a);
    e.rdata = (wr || e.err) ? 32'h0 : ((idx == 4'd0) ? ID : shadow[b][idx]);
    e.waits = b ? 32'd3 : 32'd0;
    sb.push_back(e);
    if (e.err) mcnt[b] = (mcnt[b] == 255) ? 255 : mcnt[b] + 1;
    else if (wr) shadow[b][idx] = d;

    drive(b, 1'b1, 1'b0, wr, a, d);
    @(negedge clk);
    sample(b, rdy, err, rd, cnt, prot);
    check("setup_pready", 32'(rdy), 32'd0);
    @(posedge clk); #1;
    drive(b, 1'b1, 1'b1, wr, a, d);

    waits = 0;
    got   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sample(b, rdy, err, rd, cnt, prot);
      if (rdy) begin
        got = 1'b1;
        break;
      end
      waits++;
      if (glitch && waits == 1) drive(b, 1'b1, 1'b1, wr, a ^ 32'h34, d);
    end
    if (!got) check("pready_timeout", 32'd0, 32'd1);

    e = sb.pop_front();
    check("wait_cycles", 32'(waits), e.waits);
    check("pslverr", 32'(err), 32'(e.err));
    if (!wr) check("prdata", rd, e.rdata);

    @(posedge clk); #1;
    sample(b, rdy, err, rd, cnt, prot);
    check("err_cnt", 32'(cnt), mcnt[b]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rdy, err, prot;
    logic [31:0] rd;
    logic [7:0]  cnt;

    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset_model(0);
    reset_model(1);
    repeat (3) @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++) begin
      sample(b[0], rdy, err, rd, cnt, prot);
      check("rst_pready", 32'(rdy), 32'd0);
      check("rst_pslverr", 32'(err), 32'd0);
      check("rst_prdata", rd, 32'd0);
      check("rst_err_cnt", 32'(cnt), 32'd0);
      check("rst_prot_err", 32'(prot), 32'd0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;

    // Zero-wait write then read.
    xfer(0, 1, 32'h08, 32'h1234_5678, 0); idle(0);
    xfer(0, 0, 32'h08, 32'h0, 0);         idle(0);

    // Three wait states on the ID register.
    xfer(1, 0, 32'h00, 32'h0, 0); idle(1);

    // Read-only, out-of-window and misaligned writes.
    xfer(0, 1, 32'h00, 32'hFFFF_FFFF, 0);
    xfer(0, 1, 32'h40, 32'hFFFF_FFFF, 0);
    xfer(0, 1, 32'h06, 32'hFFFF_FFFF, 0);
    idle(0);
    sample(0, rdy, err, rd, cnt, prot);
    check("err_cnt_three", 32'(cnt), 32'd3);
    xfer(0, 0, 32'h00, 32'h0, 0);
    xfer(0, 0, 32'h04, 32'h0, 0);
    xfer(0, 0, 32'h08, 32'h0, 0);
    idle(0);

    // Back-to-back write and read with no idle cycle.
    xfer(0, 1, 32'h0C, 32'hCAFE_F00D, 0);
    xfer(0, 0, 32'h0C, 32'h0, 0);
    idle(0);

    // Error counter saturation, then a clean read.
    for (int i = 0; i < 300; i++) begin
      xfer(0, 0, 32'h100, 32'h0, 0);
      idle(0);
    end
    sample(0, rdy, err, rd, cnt, prot);
    check("err_cnt_sat", 32'(cnt), 32'hFF);
    xfer(0, 0, 32'h0C, 32'h0, 0); idle(0);

    // Reset asserted in the middle of a waited write.
    xfer(1, 1, 32'h10, 32'h1111_1111, 0); idle(1);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h2222_2222);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h2222_2222);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    sample(1, rdy, err, rd, cnt, prot);
    check("midrst_pready", 32'(rdy), 32'd0);
    check("midrst_pslverr", 32'(err), 32'd0);
    check("midrst_prdata", rd, 32'd0);
    check("midrst_err_cnt", 32'(cnt), 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset_model(1);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    xfer(1, 0, 32'h10, 32'h0, 0); idle(1);

    // Address change during a wait state.
    xfer(1, 1, 32'h08, 32'h5A5A_5A5A, 0); idle(1);
    xfer(1, 0, 32'h08, 32'h0, 1);         idle(1);
    sample(1, rdy, err, rd, cnt, prot);
    check("prot_err_set", 32'(prot), 32'(EXP_PROT_B));
    xfer(1, 0, 32'h00, 32'h0, 0); idle(1);
    sample(1, rdy, err, rd, cnt, prot);
    check("prot_err_sticky", 32'(prot), 32'(EXP_PROT_B));
    sample(0, rdy, err, rd, cnt, prot);
    check("prot_err_clean", 32'(prot), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
